// File: rtl/mpe_result_pack.sv
// mpe_result_pack
// Packs the non-back-pressurable 32-bit result stream from matrix_pe into
// LANES-wide lines, buffers them in a small line FIFO and writes them to the
// output RAM over a valid/ready port at consecutive addresses from a base.
//
// state | meaning
// IDLE  | waiting for cfg_start
// RUN   | accepting results and packing lines
// DRAIN | all results taken, waiting for the line FIFO to empty
// DONE  | job complete, done pulses on the following cycle
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   cfg_start/base_addr/count  job start pulse, first line address, result count
//   mpe_result, mpe_vld_o      result word and strobe from matrix_pe
//   wb_sram_data/addr/valid    head line of the FIFO toward the RAM
//   wb_sram_ready              RAM accepts the head line
//   busy, done, err            job status; err is sticky until the next start
module mpe_result_pack #(
  parameter int LANES = 16,
  parameter int DEPTH = 2,
  parameter int AW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [AW-1:0]       cfg_base_addr,
  input  logic [15:0]         cfg_count,
  input  logic [31:0]         mpe_result,
  input  logic                mpe_vld_o,
  output logic [LANES*32-1:0] wb_sram_data,
  output logic [AW-1:0]       wb_sram_addr,
  output logic                wb_sram_valid,
  input  logic                wb_sram_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int LW  = LANES * 32;
  localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  base_q;
  logic [15:0]    cnt_q;
  logic [15:0]    k_q;
  logic [LIW-1:0] lane_q;
  logic [AW-1:0]  line_q;
  logic [LW-1:0]  pack_q;
  logic           err_q;
  logic           done_q;

  logic [LW-1:0]  mem_data_q [DEPTH];
  logic [AW-1:0]  mem_addr_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]  fcnt_q;

  logic           start_ok, take, stray, last_res, line_end;
  logic           fifo_empty, fifo_full, pop, push, drop;
  logic [LW-1:0]  line_w;
  logic [AW-1:0]  push_addr;

  assign start_ok   = cfg_start && (state_q == S_IDLE);
  assign take       = mpe_vld_o && (state_q == S_RUN);
  assign stray      = mpe_vld_o && (state_q != S_RUN);
  assign last_res   = take && (k_q == cnt_q - 16'd1);
  assign line_end   = take && ((lane_q == LIW'(LANES - 1)) || last_res);
  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == CW'(DEPTH));
  assign pop        = !fifo_empty && wb_sram_ready;
  // A full FIFO still accepts the line when the head leaves in the same cycle.
  assign push       = line_end && (!fifo_full || pop);
  assign drop       = line_end && !push;
  assign push_addr  = base_q + line_q;

  // Pack register with the incoming word merged in, so a completing line
  // carries its final word without an extra cycle.
  always_comb begin
    line_w = pack_q;
    line_w[{lane_q, 5'b0} +: 32] = mpe_result;
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cfg_start) state_d = (cfg_count == 16'd0) ? S_DONE : S_RUN;
      S_RUN:   if (last_res) state_d = S_DRAIN;
      // Leave as soon as the final line is handshaked so done follows the
      // last write by one cycle.
      S_DRAIN: if (fifo_empty || ((fcnt_q == CW'(1)) && pop)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    done = done_q;
    err  = err_q;
  end

  // ---------------- packing datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      cnt_q  <= '0;
      k_q    <= '0;
      lane_q <= '0;
      line_q <= '0;
      pack_q <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      if (start_ok) begin
        base_q <= cfg_base_addr;
        cnt_q  <= cfg_count;
        k_q    <= '0;
        lane_q <= '0;
        line_q <= '0;
        pack_q <= '0;
      end else if (take) begin
        k_q <= k_q + 16'd1;
        if (line_end) begin
          pack_q <= '0;
          lane_q <= '0;
          // Advances on drop too, so later lines keep their nominal address.
          line_q <= line_q + AW'(1);
        end else begin
          pack_q <= line_w;
          lane_q <= lane_q + LIW'(1);
        end
      end
      if (stray || drop)  err_q <= 1'b1;
      else if (start_ok)  err_q <= 1'b0;
    end
  end

  // ---------------- line FIFO ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + CW'(1);
        2'b01:   fcnt_q <= fcnt_q - CW'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= line_w;
      mem_addr_q[wr_ptr_q] <= push_addr;
    end
  end

  // Head is gated by valid so the port reads zero whenever nothing is queued.
  assign wb_sram_valid = !fifo_empty;
  assign wb_sram_data  = fifo_empty ? '0 : mem_data_q[rd_ptr_q];
  assign wb_sram_addr  = fifo_empty ? '0 : mem_addr_q[rd_ptr_q];

endmodule

// File: tb/tb_mpe_result_pack.sv
module tb_mpe_result_pack;
  localparam int LANES = 16;
  localparam int DEPTH = 2;
  localparam int AW    = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_start;
  logic [AW-1:0]  cfg_base_addr;
  logic [15:0]    cfg_count;
  logic [31:0]    mpe_result;
  logic           mpe_vld_o;
  logic [511:0]   wb_sram_data;
  logic [AW-1:0]  wb_sram_addr;
  logic           wb_sram_valid;
  logic           wb_sram_ready;
  logic           busy, done, err;

  mpe_result_pack #(.LANES(LANES), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr), .cfg_count(cfg_count),
    .mpe_result(mpe_result), .mpe_vld_o(mpe_vld_o),
    .wb_sram_data(wb_sram_data), .wb_sram_addr(wb_sram_addr),
    .wb_sram_valid(wb_sram_valid), .wb_sram_ready(wb_sram_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int ec = 0;
  always @(posedge clk) ec++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, ec);
    end
  endtask

  // Reference model: lines expected to be written, in order.
  typedef struct {
    logic [AW-1:0] addr;
    logic [511:0]  data;
  } wr_t;
  wr_t  mq[$];
  logic err_exp;
  int   n_wr;

  // One job. Results are random (mode 0) or seed+k (mode 1). Ready is held
  // low for stall_cyc cycles after start, then low with probability stall_pct%.
  task automatic run_job(input logic [15:0] base, input int count, input int mode,
                         input logic [31:0] seed, input int gap_pct, input int stall_pct,
                         input int stall_cyc, input bit inject_start,
                         input int exp_writes, input int exp_err_end);
    logic [511:0] cur;
    wr_t          w;
    int k, lane, line_i, s, done_edge, budget;
    bit hs;
    @(negedge clk);
    cfg_start = 1'b1; cfg_base_addr = base; cfg_count = count[15:0];
    mpe_vld_o = 1'b0;
    s = ec + 1;
    err_exp = 1'b0;
    done_edge = (count == 0) ? s + 1 : -1;
    k = 0; lane = 0; line_i = 0; cur = '0; n_wr = 0; budget = 0;
    forever begin
      @(negedge clk);
      cfg_start = 1'b0;
      check("done", done, (ec == done_edge));
      check("err", err, err_exp);
      check("busy", busy, (ec >= s) && !(done_edge >= 0 && ec >= done_edge - 1));
      check("valid", wb_sram_valid, mq.size() > 0);
      if (done_edge >= 0 && ec > done_edge) break;
      if (++budget > 3000) begin
        check("timeout", 1'b1, 1'b0);
        break;
      end
      wb_sram_ready = (ec - s < stall_cyc) ? 1'b0 : ($urandom_range(99) >= stall_pct);
      if (inject_start && ec == s + 3) begin
        cfg_start = 1'b1; cfg_base_addr = base ^ 16'h5A5A; cfg_count = 16'd3;
      end
      if (k < count && $urandom_range(99) >= gap_pct) begin
        mpe_vld_o  = 1'b1;
        mpe_result = (mode == 1) ? seed + 32'(k) : $urandom;
      end else begin
        mpe_vld_o  = 1'b0;
        mpe_result = $urandom;
      end
      hs = (mq.size() > 0) && wb_sram_ready;
      if (hs) begin
        check("addr", wb_sram_addr, mq[0].addr);
        check("data", wb_sram_data, mq[0].data);
        void'(mq.pop_front());
        n_wr++;
      end
      if (mpe_vld_o) begin
        cur[lane*32 +: 32] = mpe_result;
        k++; lane++;
        if (lane == LANES || k == count) begin
          if (mq.size() < DEPTH) begin
            w.addr = base + line_i[15:0];
            w.data = cur;
            mq.push_back(w);
          end else begin
            err_exp = 1'b1;
          end
          line_i++; lane = 0; cur = '0;
        end
      end
      if (hs && mq.size() == 0 && k == count && done_edge < 0)
        done_edge = ec + 2;
    end
    mpe_vld_o = 1'b0;
    cfg_start = 1'b0;
    if (exp_writes >= 0) check("n_writes", 32'(n_wr), 32'(exp_writes));
    if (exp_err_end >= 0) check("err_end", err, exp_err_end[0]);
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_base_addr = '0; cfg_count = '0;
    mpe_result = '0; mpe_vld_o = 1'b0; wb_sram_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", wb_sram_valid, 1'b0);
    check("rst_data", wb_sram_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // single full line, partial last line, zero count, wrap
    run_job(16'h0100, 16, 1, 32'd1,    0, 0, 0, 0, 1, 0);
    run_job(16'h0100, 20, 1, 32'hA0,   0, 0, 0, 0, 2, 0);
    run_job(16'h0040, 0,  0, 32'd0,    0, 0, 0, 0, 0, 0);
    run_job(16'hFFFF, 32, 0, 32'd0,    0, 0, 0, 0, 2, 0);
    // back-pressure overflow: third line dropped
    run_job(16'h0300, 48, 1, 32'h1000, 0, 0, 60, 0, 2, 1);

    // stray result in IDLE
    @(negedge clk);
    mpe_vld_o = 1'b1; mpe_result = 32'hDEAD;
    @(negedge clk);
    mpe_vld_o = 1'b0;
    check("stray_err", err, 1'b1);
    check("stray_valid", wb_sram_valid, 1'b0);

    // start during RUN ignored; this job's start also clears err
    run_job(16'h0500, 24, 0, 32'd0, 0, 0, 0, 1, 2, 0);

    // reset mid-job with a buffered line and a partial line
    @(negedge clk);
    wb_sram_ready = 1'b0;
    cfg_start = 1'b1; cfg_base_addr = 16'h0700; cfg_count = 16'd32;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 26; i++) begin
      mpe_vld_o = 1'b1; mpe_result = $urandom;
      @(negedge clk);
    end
    mpe_vld_o = 1'b0;
    check("pre_rst_valid", wb_sram_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", wb_sram_valid, 1'b0);
    check("mid_rst_data", wb_sram_data, '0);
    check("mid_rst_addr", wb_sram_addr, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wb_sram_ready = 1'b1;
    mq.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_valid", wb_sram_valid, 1'b0);
      check("post_rst_done", done, 1'b0);
    end
    run_job(16'h0800, 16, 1, 32'd7, 0, 0, 0, 0, 1, 0);

    // randomized jobs
    for (int j = 0; j < 10; j++) begin
      run_job(16'($urandom), $urandom_range(1, 70), 0, 32'd0,
              $urandom_range(0, 40), $urandom_range(0, 60),
              ($urandom_range(3) == 0) ? 40 : 0, 0, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
